// File: rtl/regfile8_sb.sv
// 8-entry register file with write-through bypass and a per-register busy scoreboard.
// Each register and its busy bit live in one entry cell; the top decodes indices and muxes reads.
module regfile8_sb_entry #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             set,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] q,
    output logic             busy
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (we)
                q <= wr_data;
            // A newer producer supersedes the retiring one, so set beats clear.
            if (set)
                busy <= 1'b1;
            else if (we)
                busy <= 1'b0;
        end
    end

endmodule

module regfile8_sb #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2:0]       dest,
    input  logic [width-1:0] wr_data,
    input  logic [2:0]       src_a,
    input  logic [2:0]       src_b,
    output logic [width-1:0] reg_a,
    output logic [width-1:0] reg_b,
    input  logic             issue,
    input  logic [2:0]       issue_dest,
    output logic             busy_a,
    output logic             busy_b,
    output logic [7:0]       busy_vec
);

    logic [7:0][width-1:0] regs;
    logic [7:0]            busy;
    logic [7:0]            we_dec;
    logic [7:0]            set_dec;
    logic                  byp_a;
    logic                  byp_b;

    always_comb begin
        we_dec  = load  ? (8'b1 << dest)       : 8'b0;
        set_dec = issue ? (8'b1 << issue_dest) : 8'b0;
    end

    for (genvar i = 0; i < 8; i++) begin : g_entry
        regfile8_sb_entry #(.width(width)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .we      (we_dec[i]),
            .set     (set_dec[i]),
            .wr_data (wr_data),
            .q       (regs[i]),
            .busy    (busy[i])
        );
    end

    // Bypass is suppressed during reset so reads see the cleared file, not wr_data.
    assign byp_a = !rst && load && (dest == src_a);
    assign byp_b = !rst && load && (dest == src_b);

    assign reg_a    = byp_a ? wr_data : regs[src_a];
    assign reg_b    = byp_b ? wr_data : regs[src_b];
    assign busy_a   = busy[src_a] && !byp_a;
    assign busy_b   = busy[src_b] && !byp_b;
    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile8_sb.sv
// Bench for regfile8_sb: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an array-based reference model.
module tb_regfile8_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [2:0]  dest;
    logic [15:0] wr_data;
    logic [2:0]  src_a, src_b;
    logic [15:0] reg_a, reg_b;
    logic        issue;
    logic [2:0]  issue_dest;
    logic        busy_a, busy_b;
    logic [7:0]  busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    regfile8_sb #(.width(16)) dut (
        .clk(clk), .rst(rst), .load(load), .dest(dest), .wr_data(wr_data),
        .src_a(src_a), .src_b(src_b), .reg_a(reg_a), .reg_b(reg_b),
        .issue(issue), .issue_dest(issue_dest),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [2:0]  dest;
        logic [15:0] wd;
        logic [2:0]  sa, sb;
        logic        issue;
        logic [2:0]  idest;
        logic [15:0] ea, eb;
        logic        ba, bb;
        logic [7:0]  ev;
    } vec_t;

    vec_t tbl[14];

    // Reference model: plain register and busy arrays.
    logic [15:0] mdl_r[8];
    logic        mdl_b[8];

    function automatic vec_t mk(logic l, logic [2:0] d, logic [15:0] w, logic [2:0] a, logic [2:0] b,
                                logic i, logic [2:0] id, logic [15:0] ea, logic [15:0] eb,
                                logic ba, logic bb, logic [7:0] ev);
        vec_t v;
        v.load = l; v.dest = d; v.wd = w; v.sa = a; v.sb = b; v.issue = i; v.idest = id;
        v.ea = ea; v.eb = eb; v.ba = ba; v.bb = bb; v.ev = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                           input logic ba, input logic bb, input logic [7:0] ev);
        chk({tag, " reg_a"}, reg_a, ea);
        chk({tag, " reg_b"}, reg_b, eb);
        chk({tag, " busy_a"}, 16'(busy_a), 16'(ba));
        chk({tag, " busy_b"}, 16'(busy_b), 16'(bb));
        chk({tag, " busy_vec"}, 16'(busy_vec), 16'(ev));
    endtask

    task automatic idle();
        load = 0; dest = 0; wr_data = 0; issue = 0; issue_dest = 0; src_a = 0; src_b = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) begin
            mdl_r[i] = '0;
            mdl_b[i] = 1'b0;
        end
    endtask

    // Pulse reset between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        #1;
        rst = 0;
        mdl_reset();
    endtask

    initial begin
        logic [15:0] ea, eb;
        logic        ba, bb;
        logic [7:0]  ev;

        tbl[0]  = mk(1, 3, 16'h1234, 3, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 8'h00);
        tbl[1]  = mk(0, 0, 16'h0000, 3, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 8'h00);
        tbl[2]  = mk(1, 5, 16'hABCD, 5, 5, 0, 0, 16'hABCD, 16'hABCD, 0, 0, 8'h00);
        tbl[3]  = mk(0, 0, 16'h0000, 5, 3, 0, 0, 16'hABCD, 16'h1234, 0, 0, 8'h00);
        tbl[4]  = mk(0, 0, 16'h0000, 2, 2, 1, 2, 16'h0000, 16'h0000, 0, 0, 8'h00);
        tbl[5]  = mk(0, 0, 16'h0000, 2, 3, 0, 0, 16'h0000, 16'h1234, 1, 0, 8'h04);
        tbl[6]  = mk(1, 2, 16'h0042, 2, 2, 0, 0, 16'h0042, 16'h0042, 0, 0, 8'h04);
        tbl[7]  = mk(0, 0, 16'h0000, 2, 1, 0, 0, 16'h0042, 16'h0000, 0, 0, 8'h00);
        tbl[8]  = mk(0, 0, 16'h0000, 6, 6, 1, 6, 16'h0000, 16'h0000, 0, 0, 8'h00);
        tbl[9]  = mk(1, 6, 16'h7777, 6, 2, 1, 6, 16'h7777, 16'h0042, 0, 0, 8'h40);
        tbl[10] = mk(0, 0, 16'h0000, 6, 6, 0, 0, 16'h7777, 16'h7777, 1, 1, 8'h40);
        tbl[11] = mk(0, 0, 16'h0000, 0, 6, 1, 6, 16'h0000, 16'h7777, 0, 1, 8'h40);
        tbl[12] = mk(1, 6, 16'h0001, 5, 6, 0, 0, 16'hABCD, 16'h0001, 0, 0, 8'h40);
        tbl[13] = mk(0, 0, 16'h0000, 6, 6, 0, 0, 16'h0001, 16'h0001, 0, 0, 8'h00);

        // Reset with load/issue active: both must be ignored.
        idle();
        rst = 1; load = 1; dest = 3; wr_data = 16'hFFFF; src_a = 3; src_b = 3;
        issue = 1; issue_dest = 3;
        tick(); tick();
        chk_all("rst_active", 16'h0000, 16'h0000, 0, 0, 8'h00);
        @(negedge clk);
        idle();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            src_a = 3'(i); src_b = 3'(7 - i);
            #1;
            chk_all($sformatf("post_rst%0d", i), 16'h0000, 16'h0000, 0, 0, 8'h00);
        end

        // Directed vector table; inputs change just after an edge, checks before the next.
        tick();
        for (int k = 0; k < 14; k++) begin
            load = tbl[k].load; dest = tbl[k].dest; wr_data = tbl[k].wd;
            src_a = tbl[k].sa; src_b = tbl[k].sb;
            issue = tbl[k].issue; issue_dest = tbl[k].idest;
            #2;
            chk_all($sformatf("tbl%0d", k), tbl[k].ea, tbl[k].eb, tbl[k].ba, tbl[k].bb, tbl[k].ev);
            tick();
        end

        // Bypass visible before the edge, but the register keeps old data if load drops first.
        idle();
        load = 1; dest = 4; wr_data = 16'h5555; src_a = 4; src_b = 5;
        #1;
        chk("skip_edge_byp", reg_a, 16'h5555);
        load = 0;
        #1;
        chk("skip_edge_old", reg_a, 16'h0000);
        chk("skip_edge_b", reg_b, 16'hABCD);
        tick();

        // Sweep all registers with distinct values.
        for (int i = 0; i < 8; i++) begin
            load = 1; dest = 3'(i); wr_data = 16'h1111 * 16'(i + 1) ^ 16'h0F0F;
            tick();
        end
        load = 0;
        for (int i = 0; i < 8; i++) begin
            src_a = 3'(i); src_b = 3'(7 - i);
            #1;
            chk($sformatf("sweep_a%0d", i), reg_a, 16'h1111 * 16'(i + 1) ^ 16'h0F0F);
            chk($sformatf("sweep_b%0d", i), reg_b, 16'h1111 * 16'(8 - i) ^ 16'h0F0F);
        end

        // Fill the scoreboard, then reset asynchronously mid-cycle.
        tick();
        for (int i = 0; i < 8; i++) begin
            issue = 1; issue_dest = 3'(i);
            tick();
        end
        issue = 0;
        #1;
        chk("busy_full", 16'(busy_vec), 16'h00FF);
        @(negedge clk);
        rst = 1;
        load = 1; dest = 2; wr_data = 16'hFFFF;
        #1;
        chk("async_busy_vec", 16'(busy_vec), 16'h0000);
        for (int i = 0; i < 8; i++) begin
            src_a = 3'(i); src_b = 3'(i);
            #0.5;
            chk($sformatf("async_reg%0d", i), reg_a, 16'h0000);
        end
        src_a = 2;
        #0.5;
        chk("async_no_byp", reg_b, 16'h0000);
        rst = 0;
        idle();
        mdl_reset();
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            load = 1'($urandom_range(0, 1)); dest = 3'($urandom); wr_data = 16'($urandom);
            issue = 1'($urandom_range(0, 1)); issue_dest = 3'($urandom);
            src_a = 3'($urandom); src_b = ($urandom_range(0, 3) == 0) ? src_a : 3'($urandom);
            ea = (load && dest == src_a) ? wr_data : mdl_r[src_a];
            eb = (load && dest == src_b) ? wr_data : mdl_r[src_b];
            ba = mdl_b[src_a] && !(load && dest == src_a);
            bb = mdl_b[src_b] && !(load && dest == src_b);
            for (int i = 0; i < 8; i++) ev[i] = mdl_b[i];
            #2;
            chk_all($sformatf("rnd%0d", c), ea, eb, ba, bb, ev);
            tick();
            if (load) begin
                mdl_r[dest] = wr_data;
                mdl_b[dest] = 1'b0;
            end
            if (issue) mdl_b[issue_dest] = 1'b1;
            if (c == 200) begin
                idle();
                pulse_reset();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
